// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM state type, register tag width.
package alu_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SGT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ex_state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU: arithmetic, logic and compares.
// Shift opcodes pass A through; only the zero-amount shift uses this path.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] z_o
);

    logic sa, sb, lt_s, gt_s, lt_u;

    // Sign-aware compare: differing signs decide directly, so no overflow can occur.
    always_comb begin
        sa   = a_i[WIDTH-1];
        sb   = b_i[WIDTH-1];
        lt_s = (sa != sb) ? sa : (a_i[WIDTH-2:0] < b_i[WIDTH-2:0]);
        gt_s = (sa != sb) ? sb : (a_i[WIDTH-2:0] > b_i[WIDTH-2:0]);
        lt_u = (a_i < b_i);
    end

    always_comb begin
        z_o = '0;
        case (op_i)
            OP_ADD:  z_o = a_i + b_i;
            OP_SUB:  z_o = a_i - b_i;
            OP_AND:  z_o = a_i & b_i;
            OP_OR:   z_o = a_i | b_i;
            OP_XOR:  z_o = a_i ^ b_i;
            OP_SLT:  z_o = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SGT:  z_o = {{(WIDTH-1){1'b0}}, gt_s};
            OP_SLTU: z_o = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLL, OP_SRL, OP_SRA: z_o = a_i;
            default: z_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Pipelined execute stage: single-cycle ops via alu_comb, iterative 1-bit/cycle shifts
// under an IDLE/SHIFT FSM, with valid/ready handshakes on input and output.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_z,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  busy
);

    ex_state_t             state_q, state_d;
    logic [WIDTH-1:0]      wv_q, wv_d;
    logic [3:0]            wop_q, wop_d;
    logic [4:0]            wk_q, wk_d;
    logic [REG_ADDR_W-1:0] wrd_q, wrd_d;
    logic                  ov_q, ov_d;
    logic [WIDTH-1:0]      oz_q, oz_d;
    logic [REG_ADDR_W-1:0] ord_q, ord_d;

    logic [WIDTH-1:0] comb_z;
    logic [WIDTH-1:0] shift_nxt;
    logic [4:0]       amt;
    logic             accept;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  return v << 1;
            OP_SRL:  return v >> 1;
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op_i (in_op),
        .a_i  (in_a),
        .b_i  (in_b),
        .z_o  (comb_z)
    );

    assign amt       = in_b[4:0];
    assign in_ready  = (state_q != SHIFT) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign shift_nxt = shift1(wop_q, wv_q);
    assign busy      = (state_q == SHIFT);
    assign out_valid = ov_q;
    assign out_z     = oz_q;
    assign out_rd    = ord_q;

    always_comb begin
        state_d = state_q;
        wv_d    = wv_q;
        wop_d   = wop_q;
        wk_d    = wk_q;
        wrd_d   = wrd_q;
        ov_d    = ov_q;
        oz_d    = oz_q;
        ord_d   = ord_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift(in_op) && (amt != 5'd0)) begin
                        wv_d    = in_a;
                        wop_d   = in_op;
                        wk_d    = amt;
                        wrd_d   = in_rd;
                        ov_d    = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        oz_d  = comb_z;
                        ord_d = in_rd;
                        ov_d  = 1'b1;
                    end
                end else if (ov_q && out_ready) begin
                    ov_d = 1'b0;
                end
            end
            SHIFT: begin
                wv_d = shift_nxt;
                wk_d = wk_q - 5'd1;
                // The last step publishes directly, so no partial value ever reaches out_z.
                if (wk_q == 5'd1) begin
                    oz_d    = shift_nxt;
                    ord_d   = wrd_q;
                    ov_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wv_q    <= '0;
            wop_q   <= '0;
            wk_q    <= '0;
            wrd_q   <= '0;
            ov_q    <= 1'b0;
            oz_q    <= '0;
            ord_q   <= '0;
        end else begin
            state_q <= state_d;
            wv_q    <= wv_d;
            wop_q   <= wop_d;
            wk_q    <= wk_d;
            wrd_q   <= wrd_d;
            ov_q    <= ov_d;
            oz_q    <= oz_d;
            ord_q   <= ord_d;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Table-driven bench for alu_exec with a result scoreboard and hand-written timing sequences.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_rd;
    logic        busy;

    alu_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_rd    (out_rd),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] z;
    } vec_t;

    typedef struct packed {
        logic [31:0] z;
        logic [4:0]  rd;
    } exp_t;

    localparam int NV = 20;
    vec_t  vecs[NV];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic [31:0] cur_z;
    bit    got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: evaluate handshakes at the falling edge, then advance past the rising edge.
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_z", out_z, e.z);
                check("sb_rd", 32'(out_rd), 32'(e.rd));
            end
        end
        if (acc) sb.push_back('{z: cur_z, rd: in_rd});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] z);
        bit acc;
        in_op = op; in_a = a; in_b = b; in_rd = rd; cur_z = z;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) step(acc);
        in_valid = 1'b0;
        check("accept_in_time", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (sb.size() > 0); i++) step(acc);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  32'h0000_0005, 32'h0000_0007, 5'd3,  32'h0000_000C};
        vecs[1]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 5'd1,  32'h0000_0000};
        vecs[2]  = '{4'd1,  32'h0000_0003, 32'h0000_0005, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd4,  32'hF000_F000};
        vecs[4]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd5,  32'hFFF0_FFF0};
        vecs[5]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6,  32'h0FF0_0FF0};
        vecs[6]  = '{4'd6,  32'h7FFF_FFFF, 32'h8000_0000, 5'd7,  32'h0000_0001};
        vecs[7]  = '{4'd6,  32'h8000_0000, 32'h7FFF_FFFF, 5'd8,  32'h0000_0000};
        vecs[8]  = '{4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 5'd9,  32'h0000_0001};
        vecs[9]  = '{4'd6,  32'h0000_0005, 32'h0000_0005, 5'd10, 32'h0000_0000};
        vecs[10] = '{4'd5,  32'h8000_0000, 32'h0000_0001, 5'd11, 32'h0000_0001};
        vecs[11] = '{4'd5,  32'h7FFF_FFFF, 32'h8000_0000, 5'd12, 32'h0000_0000};
        vecs[12] = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 5'd13, 32'h0000_0000};
        vecs[13] = '{4'd8,  32'h1234_5678, 32'h0000_0020, 5'd14, 32'h1234_5678};
        vecs[14] = '{4'd8,  32'h0000_0001, 32'h0000_0003, 5'd15, 32'h0000_0008};
        vecs[15] = '{4'd9,  32'h8000_0000, 32'h0000_001F, 5'd16, 32'h0000_0001};
        vecs[16] = '{4'd10, 32'h8000_0010, 32'h0000_0004, 5'd17, 32'hF800_0001};
        vecs[17] = '{4'd10, 32'h4000_0000, 32'h0000_0022, 5'd18, 32'h1000_0000};
        vecs[18] = '{4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 5'd19, 32'h0000_0000};
        vecs[19] = '{4'd11, 32'h0000_0001, 32'h0000_0001, 5'd20, 32'h0000_0000};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        out_ready = 1'b1; cur_z = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_z", out_z, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD with 1-cycle latency
        send(4'd0, 32'd5, 32'd7, 5'd3, 32'd12);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_z", out_z, 32'd12);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_in_ready", 32'(in_ready), 32'd1);

        // Vector table
        for (int i = 0; i < NV; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].z);
        drain();

        // SRA by 4: busy for 4 cycles, result on the 4th edge
        send(4'd10, 32'h8000_0010, 32'h0000_0004, 5'd21, 32'hF800_0001);
        for (int i = 0; i < 4; i++) begin
            check("sra_busy", 32'(busy), 32'd1);
            check("sra_in_ready", 32'(in_ready), 32'd0);
            check("sra_no_valid", 32'(out_valid), 32'd0);
            step(got);
        end
        check("sra_done_busy", 32'(busy), 32'd0);
        check("sra_done_valid", 32'(out_valid), 32'd1);
        check("sra_done_z", out_z, 32'hF800_0001);
        drain();

        // Zero-amount shift and unused opcode complete in one cycle
        send(4'd8, 32'hA5A5_A5A5, 32'h0000_0020, 5'd22, 32'hA5A5_A5A5);
        check("sll0_valid", 32'(out_valid), 32'd1);
        check("sll0_busy", 32'(busy), 32'd0);
        check("sll0_z", out_z, 32'hA5A5_A5A5);
        send(4'd13, 32'h1357_9BDF, 32'hFFFF_FFFF, 5'd23, 32'h0);
        check("op13_valid", 32'(out_valid), 32'd1);
        check("op13_z", out_z, 32'h0);
        drain();

        // Back-pressure, then drain and accept on the same edge
        out_ready = 1'b0;
        send(4'd0, 32'd1, 32'd2, 5'd4, 32'd3);
        in_op = 4'd1; in_a = 32'd9; in_b = 32'd4; in_rd = 5'd6; cur_z = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(got);
            check("bp_no_accept", 32'(got), 32'd0);
            check("bp_z_hold", out_z, 32'd3);
            check("bp_rd_hold", 32'(out_rd), 32'd4);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step(got);
        in_valid = 1'b0;
        check("bp_accept", 32'(got), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_z_new", out_z, 32'd5);
        check("bp_rd_new", 32'(out_rd), 32'd6);
        drain();

        // Reset two cycles into a long SRL
        send(4'd9, 32'hFFFF_FFFF, 32'd20, 5'd9, 32'h0000_0FFF);
        step(got);
        step(got);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_z", out_z, 32'd0);
        check("mid_rst_rd", 32'(out_rd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            step(got);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end

        send(4'd0, 32'h10, 32'h20, 5'd1, 32'h30);
        check("recover_z", out_z, 32'h30);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Pipelined execute stage of the RISC core. It sits between decode and writeback and feeds the combinational compare units (sgt and its siblings) operand pairs. It registers one result per accepted instruction. Single-cycle ALU ops complete in one cycle; shifts run iteratively, one bit position per cycle, under a small FSM. Valid/ready handshakes apply on both sides.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported; the shift amount is `in_b[4:0]`.
- `clk`  in  1  : the single clock; all state updates on its rising edge.
- `rst`  in  1  : reset, asynchronous and active-high.
- `in_valid`  in  1  : decode presents an instruction.
- `in_ready`  out  1  : stage can accept this cycle (combinational).
- `in_op`  in  4  : opcode.
- `in_a`  in  WIDTH  : operand A.
- `in_b`  in  WIDTH  : operand B.
- `in_rd`  in  5  : destination register tag, passed through.
- `out_valid`  out  1  : result register holds a valid result.
- `out_ready`  in  1  : writeback accepts the result.
- `out_z`  out  WIDTH  : result.
- `out_rd`  out  5  : tag of the result.
- `busy`  out  1  : high while FSM is in SHIFT.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed A<B.
  - 6 SGT: signed A>B.
  - 7 SLTU: unsigned A<B.
  - 8 SLL.
  - 9 SRL.
  - 10 SRA.
  - 11–15: result 0.
- Arithmetic is modulo 2^32, with no flags or exceptions.
- Compares return {31'b0, bit}. They must be exact over the full range, including overflowing differences; e.g. SGT(0x7FFFFFFF, 0x80000000) = 1.
- Shifts: amount = `in_b[4:0]`, and `in_b[31:5]` is ignored. SRA fills with the original `in_a[31]`.
- Accept = `in_valid && in_ready`.
- `in_ready = (state != SHIFT) && (!out_valid || out_ready)`.
- FSM states: IDLE and SHIFT.
- IDLE:
  - Non-shift op, or shift with amount 0: on accept, load result into `out_z`/`out_rd` and set `out_valid`. Stay in IDLE.
  - Shift with amount k>0: on accept, latch A, op, k and rd into the working registers, clear `out_valid` (the prior result drains that same cycle) and go to SHIFT.
- SHIFT: each cycle, shift the working value by 1 and decrement k. When k reaches 1, write the final value to `out_z`, set `out_valid` and return to IDLE.
- Output hold: while `out_valid && !out_ready`, `out_z` and `out_rd` are stable and no new accept occurs.
- Drain: `out_valid && out_ready` with no accept clears `out_valid`.
- Simultaneous drain and accept of a single-cycle op: `out_valid` stays 1 and the new result replaces the old.
- `busy` = (state == SHIFT).
- Ops presented while busy are not accepted. Decode holds them.

## Timing
- Reset values: `out_valid` = 0, `out_z` = 0, `out_rd` = 0, `busy` = 0, state = IDLE, working registers = 0. `in_ready` = 1 in the first cycle after reset.
- Reset asserted mid-shift aborts the shift. No partial result is ever presented.
- Single-cycle op accepted at edge N: `out_valid` = 1 after edge N.
- Shift with amount k≥1 accepted at edge N: `out_valid` = 1 after edge N+k. The earliest next accept is edge N+k+1, provided `out_ready` = 1.
- Throughput:
  - 1 op per cycle for non-shift ops, with `out_ready` held high.
  - 1 shift per k+1 cycles.
- No combinational path from `in_*` to `out_*`. `in_ready` depends only on state, `out_valid` and `out_ready`.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams `OP_ADD`…`OP_SRA`
  - FSM state typedef `ex_state_t` {IDLE, SHIFT}
  - `REG_ADDR_W` = 5
- One natural sub-module: `alu_comb`. It is purely combinational (op, a, b → z) and handles all non-iterative ops, including the signed/unsigned compares. Compares use sign-aware logic, not the sign bit of a subtraction.
- The FSM, working registers and output register live in `alu_exec`.

## Test plan
- Reset, then ADD A=5, B=7, rd=3 with `out_ready` = 1 → one cycle later `out_valid` = 1, `out_z` = 12, `out_rd` = 3. `in_ready` is never low.
- SGT(0x7FFFFFFF, 0x80000000) → 1. SGT(0x80000000, 0x7FFFFFFF) → 0. SLTU(1, 0xFFFFFFFF) → 1. SGT(5, 5) → 0.
- SRA A=0x80000010, B=4 → `busy` high for 4 cycles, `in_ready` low for those cycles, `out_z` = 0xF8000001 on the 4th edge. SLL with B=0x20 (amount 0) → result = A, latency 1.
- Back-pressure: hold `out_ready` = 0 after an ADD result → `out_z` stable, `in_ready` = 0. Release `out_ready` while a SUB 9−4 waits → same edge drains the ADD result and loads 5.
- Assert `rst` 2 cycles into SRL A=0xFFFFFFFF, B=20 → all outputs return to reset values immediately. No `out_valid` afterwards until a new accept.
- Opcode 13 with arbitrary operands → `out_z` = 0, latency 1.
